aoc_day3_sched: RTL and testbench
=================================

AOC_DAY3_SCHED -- requirements
Module: aoc_day3_sched

Interface
REQ-001 Parameter LINE_LEN, 14, digits per line (bank) expected before in_last.
REQ-002 Parameter RES_W, 41, width of the per-line result returned by the digit-selection datapath.
REQ-003 Parameter SUM_W, 48, width of the running total.
REQ-004 Parameter TIMEOUT, 64, maximum cycles spent in WAIT for dp_done.
REQ-005 clk  in  1  single clock; all state updates on the rising edge.
REQ-006 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 clr  in  1  synchronous clear of totals, counters and error.
REQ-008 in_valid  in  1  upstream digit beat valid.
REQ-009 in_ready  out  1  scheduler accepts a beat this cycle.
REQ-010 in_digit  in  4  decimal digit 0..9.
REQ-011 in_last  in  1  marks the final digit of a line.
REQ-012 dp_start  out  1  one-cycle pulse that re-arms the datapath for a new line.
REQ-013 dp_valid  out  1  dp_digit valid this cycle.
REQ-014 dp_digit  out  4  digit forwarded to the datapath.
REQ-015 dp_done  in  1  datapath result valid, single-cycle pulse.
REQ-016 dp_result  in  RES_W  selected number for the line.
REQ-017 dp_error  in  1  datapath error flag, sampled with dp_done.
REQ-018 sum_out  out  SUM_W  running sum of accepted line results.
REQ-019 lines_out  out  16  count of completed lines.
REQ-020 busy  out  1  high whenever state is not IDLE.
REQ-021 error  out  1  sticky error flag.

Function
REQ-022 The FSM SHALL have states IDLE, START, FEED, WAIT and ACC.
REQ-023 In IDLE, in_ready=0; in_valid=1 moves the FSM to START without consuming the beat.
REQ-024 START SHALL hold dp_start=1 for exactly one cycle, then go to FEED.
REQ-025 In FEED, in_ready=1; each accepted beat (in_valid&in_ready) SHALL appear on dp_valid/dp_digit exactly one cycle later; no beat is accepted outside FEED.
REQ-026 A digit >9 SHALL be forwarded as 0 and SHALL set error.
REQ-027 An accepted beat with in_last=1 SHALL move FEED to WAIT; if that beat is not the LINE_LEN-th digit, error SHALL be set.
REQ-028 When LINE_LEN digits are accepted without in_last, error SHALL be set, the FSM SHALL go to WAIT, and later beats wait for the next line.
REQ-029 In WAIT, in_ready=0; dp_done=1 moves the FSM to ACC and captures dp_result and dp_error.
REQ-030 A watchdog in WAIT SHALL set error and return the FSM to IDLE after TIMEOUT cycles without dp_done; sum_out and lines_out are then unchanged.
REQ-031 In ACC, sum_out SHALL add the zero-extended result mod 2^SUM_W, with a carry-out setting error; lines_out SHALL increment mod 2^16; a captured dp_error SHALL set error; the FSM then returns to IDLE.
REQ-032 dp_done outside WAIT SHALL be ignored.
REQ-033 clr=1 in any state SHALL, next edge, zero sum_out, lines_out, error and the counters, force IDLE and drop dp_valid; clr takes priority over handshakes.
REQ-034 busy SHALL equal (state != IDLE), registered with the state.

Reset
REQ-035 rst_n=0 SHALL immediately force IDLE and zero in_ready, dp_start, dp_valid, dp_digit, sum_out, lines_out, busy, error and all internal counters, including mid-line.
REQ-036 After rst_n deasserts, the first line SHALL begin only from IDLE via START.

Structure
REQ-037 Package aoc_day3_pkg SHALL hold the state enum, DIGIT_W=4, MAX_DIGIT=9 and the default RES_W.
REQ-038 The WAIT timeout counter SHALL be the sub-module aoc_day3_watchdog (enable, clear, expired); everything else stays in aoc_day3_sched.

Verification
REQ-039 Reset, one line 3,6,4,7,8,9,3,6,5,8,4,6,3,4 with in_last on the 14th digit, bench returns 986 three cycles later -> one dp_start, 14 dp_valid beats in order, sum_out=986, lines_out=1, error=0.
REQ-040 Two back-to-back lines returning 986 and 999 -> sum_out=1985, lines_out=2, dp_start pulsed twice.
REQ-041 in_last on the 10th digit, result 98 -> error=1 the cycle after last accept, sum_out=98, lines_out=1.
REQ-042 TIMEOUT=32, dp_done never asserted -> error=1 and IDLE 32 cycles after entering WAIT, lines_out=0.
REQ-043 SUM_W=12, results 4000 then 100 -> sum_out=4, error=1.
REQ-044 rst_n low at the 7th digit of a line -> all outputs 0 at once; a fresh line afterwards completes with correct sum_out.

Source files
------------

// File: rtl/aoc_day3_pkg.sv
// rtl/aoc_day3_pkg.sv - shared types and constants for the day-3 line scheduler
package aoc_day3_pkg;

    localparam int DIGIT_W   = 4;
    localparam logic [DIGIT_W-1:0] MAX_DIGIT = 4'd9;
    localparam int RES_W_DEF = 41;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_FEED  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_ACC   = 3'd4
    } state_e;

endpackage

// File: rtl/aoc_day3_if.sv
// rtl/aoc_day3_if.sv - digit stream and datapath handshake bundle
interface aoc_day3_if
    import aoc_day3_pkg::*;
#(
    parameter int RES_W = RES_W_DEF
);

    logic               in_valid;
    logic               in_ready;
    logic [DIGIT_W-1:0] in_digit;
    logic               in_last;

    logic               dp_start;
    logic               dp_valid;
    logic [DIGIT_W-1:0] dp_digit;
    logic               dp_done;
    logic [RES_W-1:0]   dp_result;
    logic               dp_error;

    // master: digit source plus datapath model; slave: the scheduler
    modport master (
        output in_valid, in_digit, in_last, dp_done, dp_result, dp_error,
        input  in_ready, dp_start, dp_valid, dp_digit
    );

    modport slave (
        input  in_valid, in_digit, in_last, dp_done, dp_result, dp_error,
        output in_ready, dp_start, dp_valid, dp_digit
    );

endinterface

// File: rtl/aoc_day3_watchdog.sv
// rtl/aoc_day3_watchdog.sv - cycle counter that flags a stalled datapath
module aoc_day3_watchdog #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic clear,
    output logic expired
);

    localparam int W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // restarts from zero every time enable drops, so each WAIT gets a full budget
    always_comb begin
        count_d = count_q;
        if (clear || !enable) begin
            count_d = '0;
        end else begin
            count_d = count_q + W'(1);
        end
    end

    assign expired = enable && (count_q == W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/aoc_day3_sched.sv
// rtl/aoc_day3_sched.sv - feeds digit lines to the selection datapath and totals results
module aoc_day3_sched
    import aoc_day3_pkg::*;
#(
    parameter int LINE_LEN = 14,
    parameter int RES_W    = RES_W_DEF,
    parameter int SUM_W    = 48,
    parameter int TIMEOUT  = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    aoc_day3_if.slave        bus,
    output logic [SUM_W-1:0] sum_out,
    output logic [15:0]      lines_out,
    output logic             busy,
    output logic             error
);

    localparam logic [2:0] IDLE  = 3'(ST_IDLE);
    localparam logic [2:0] START = 3'(ST_START);
    localparam logic [2:0] FEED  = 3'(ST_FEED);
    localparam logic [2:0] WAIT  = 3'(ST_WAIT);
    localparam logic [2:0] ACC   = 3'(ST_ACC);

    localparam int CNT_W = $clog2(LINE_LEN + 1);
    localparam int ADD_W = ((RES_W > SUM_W) ? RES_W : SUM_W) + 1;

    logic [2:0]         state_q,    state_d;
    logic [CNT_W-1:0]   cnt_q,      cnt_d;
    logic               dp_valid_q, dp_valid_d;
    logic [DIGIT_W-1:0] dp_digit_q, dp_digit_d;
    logic [RES_W-1:0]   res_q,      res_d;
    logic               derr_q,     derr_d;
    logic [SUM_W-1:0]   sum_q,      sum_d;
    logic [15:0]        lines_q,    lines_d;
    logic               error_q,    error_d;

    logic               accept;
    logic               bad_digit;
    logic               wd_expired;
    logic [ADD_W-1:0]   acc_wide;
    logic               acc_ovf;

    aoc_day3_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .enable  (state_q == WAIT),
        .clear   (clr),
        .expired (wd_expired)
    );

    assign accept    = bus.in_valid && (state_q == FEED);
    assign bad_digit = bus.in_digit > MAX_DIGIT;

    // widen both operands so any bit past SUM_W counts as a carry-out
    assign acc_wide  = ADD_W'(sum_q) + ADD_W'(res_q);
    assign acc_ovf   = |acc_wide[ADD_W-1:SUM_W];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dp_valid_d = 1'b0;
        dp_digit_d = dp_digit_q;
        res_d      = res_q;
        derr_d     = derr_q;
        sum_d      = sum_q;
        lines_d    = lines_q;
        error_d    = error_q;

        if (clr) begin
            state_d    = IDLE;
            cnt_d      = '0;
            dp_digit_d = '0;
            res_d      = '0;
            derr_d     = 1'b0;
            sum_d      = '0;
            lines_d    = '0;
            error_d    = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_d = '0;
                    if (bus.in_valid) begin
                        state_d = START;
                    end
                end
                START: begin
                    state_d = FEED;
                end
                FEED: begin
                    if (accept) begin
                        dp_valid_d = 1'b1;
                        dp_digit_d = bad_digit ? '0 : bus.in_digit;
                        cnt_d      = cnt_q + CNT_W'(1);
                        if (bad_digit) begin
                            error_d = 1'b1;
                        end
                        // a line ends on in_last or at LINE_LEN digits, whichever comes first
                        if (bus.in_last) begin
                            state_d = WAIT;
                            if (cnt_q != CNT_W'(LINE_LEN - 1)) begin
                                error_d = 1'b1;
                            end
                        end else if (cnt_q == CNT_W'(LINE_LEN - 1)) begin
                            state_d = WAIT;
                            error_d = 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (bus.dp_done) begin
                        res_d   = bus.dp_result;
                        derr_d  = bus.dp_error;
                        state_d = ACC;
                    end else if (wd_expired) begin
                        error_d = 1'b1;
                        state_d = IDLE;
                    end
                end
                ACC: begin
                    sum_d   = acc_wide[SUM_W-1:0];
                    lines_d = lines_q + 16'd1;
                    if (acc_ovf || derr_q) begin
                        error_d = 1'b1;
                    end
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            dp_valid_q <= 1'b0;
            dp_digit_q <= '0;
            res_q      <= '0;
            derr_q     <= 1'b0;
            sum_q      <= '0;
            lines_q    <= '0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dp_valid_q <= dp_valid_d;
            dp_digit_q <= dp_digit_d;
            res_q      <= res_d;
            derr_q     <= derr_d;
            sum_q      <= sum_d;
            lines_q    <= lines_d;
            error_q    <= error_d;
        end
    end

    assign bus.in_ready = (state_q == FEED);
    assign bus.dp_start = (state_q == START);
    assign bus.dp_valid = dp_valid_q;
    assign bus.dp_digit = dp_digit_q;
    assign sum_out      = sum_q;
    assign lines_out    = lines_q;
    assign busy         = (state_q != IDLE);
    assign error        = error_q;

endmodule

// File: tb/tb_aoc_day3_sched.sv
// tb/tb_aoc_day3_sched.sv - randomized line traffic against a per-line reference model
module tb_aoc_day3_sched;
    import aoc_day3_pkg::*;

    localparam int LINE_LEN = 14;
    localparam int RES_W    = 41;
    localparam int SUM_W    = 12;
    localparam int TIMEOUT  = 32;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             clr = 1'b0;
    logic [SUM_W-1:0] sum_out;
    logic [15:0]      lines_out;
    logic             busy;
    logic             error;

    aoc_day3_if #(.RES_W(RES_W)) bus ();

    aoc_day3_sched #(
        .LINE_LEN (LINE_LEN),
        .RES_W    (RES_W),
        .SUM_W    (SUM_W),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .bus       (bus.slave),
        .sum_out   (sum_out),
        .lines_out (lines_out),
        .busy      (busy),
        .error     (error)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // reference model: totals as plain integers, sticky error as a bit
    longint m_sum;
    int     m_lines;
    bit     m_err;

    int         starts_seen = 0;
    logic [3:0] mon_q[$];

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.dp_start) starts_seen++;
            if (bus.dp_valid) mon_q.push_back(bus.dp_digit);
        end
    end

    task automatic model_clear();
        m_sum = 0;
        m_lines = 0;
        m_err = 0;
    endtask

    task automatic check_totals(input string tag);
        expect_eq({tag, "_sum"},   sum_out,   m_sum);
        expect_eq({tag, "_lines"}, lines_out, m_lines);
        expect_eq({tag, "_error"}, error,     m_err);
    endtask

    task automatic do_clr();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        model_clear();
        check_totals("clr");
    endtask

    task automatic run_line(input logic [3:0] digs[$], input bit with_last,
                            input logic [RES_W-1:0] res, input bit derr,
                            input bit respond, input int abort_at);
        int     idx = 0;
        int     guard = 0;
        int     k;
        int     start0;
        bit     acc_prev;
        bit     early_err;
        longint total;
        logic [3:0] expd;

        mon_q.delete();
        start0 = starts_seen;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_digit = digs[0];
        bus.in_last  = with_last && (digs.size() == 1);
        acc_prev     = bus.in_ready;
        while (1) begin
            @(negedge clk);
            guard++;
            if (acc_prev) begin
                idx++;
                if (idx == digs.size()) break;
                bus.in_digit = digs[idx];
                bus.in_last  = with_last && (idx == digs.size() - 1);
            end
            if (idx == abort_at) begin
                rst_n = 1'b0;
                #1;
                expect_eq("rst_outs",
                          {bus.in_ready, bus.dp_start, bus.dp_valid, bus.dp_digit,
                           busy, error, lines_out, sum_out}, 64'd0);
                bus.in_valid = 1'b0;
                bus.in_last  = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                model_clear();
                return;
            end
            acc_prev = bus.in_ready;
            if (guard > 200) begin
                expect_eq("feed_stall", guard, 0);
                bus.in_valid = 1'b0;
                return;
            end
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;

        early_err = (digs.size() != LINE_LEN) || !with_last;
        foreach (digs[i]) if (digs[i] > 4'd9) early_err = 1'b1;
        m_err = m_err | early_err;
        expect_eq("err_after_last", error, m_err);

        if (respond) begin
            repeat (2) @(negedge clk);
            bus.dp_done   = 1'b1;
            bus.dp_result = res;
            bus.dp_error  = derr;
            @(negedge clk);
            bus.dp_done   = 1'b0;
            bus.dp_result = RES_W'($urandom);
            bus.dp_error  = 1'b0;
            k = 0;
            while (busy && k < 10) begin
                @(negedge clk);
                k++;
            end
            expect_eq("acc_idle", busy, 0);
            total = m_sum + longint'(res);
            if (total >= (64'd1 << SUM_W)) m_err = 1'b1;
            m_sum = total % (64'd1 << SUM_W);
            m_lines++;
            if (derr) m_err = 1'b1;
        end else begin
            k = 0;
            while (busy && k < 100) begin
                @(negedge clk);
                k++;
            end
            expect_eq("wd_cycles", k, TIMEOUT);
            m_err = 1'b1;
        end

        expect_eq("dig_count", mon_q.size(), digs.size());
        for (int i = 0; i < digs.size() && i < mon_q.size(); i++) begin
            expd = (digs[i] > 4'd9) ? 4'd0 : digs[i];
            expect_eq("dig_val", mon_q[i], expd);
        end
        expect_eq("dp_start_cnt", starts_seen - start0, 1);
        check_totals("line");
    endtask

    task automatic random_line();
        logic [3:0] digs[$];
        int  len;
        bit  with_last;
        bit  bad;
        logic [RES_W-1:0] res;
        with_last = ($urandom_range(0, 99) < 85);
        len = (with_last && $urandom_range(0, 3) == 0) ? $urandom_range(1, LINE_LEN) : LINE_LEN;
        bad = ($urandom_range(0, 9) == 0);
        for (int i = 0; i < len; i++) begin
            if (bad && i == len / 2) digs.push_back(4'($urandom_range(10, 15)));
            else                     digs.push_back(4'($urandom_range(0, 9)));
        end
        res = ($urandom_range(0, 4) == 0) ? RES_W'($urandom_range(0, 4095)) : RES_W'($urandom_range(0, 999));
        run_line(digs, with_last, res, $urandom_range(0, 9) == 0, $urandom_range(0, 19) != 0, -1);
        if ($urandom_range(0, 2) == 0) begin
            @(negedge clk);
            bus.dp_done   = 1'b1;
            bus.dp_result = RES_W'($urandom);
            bus.dp_error  = 1'b1;
            @(negedge clk);
            bus.dp_done   = 1'b0;
            bus.dp_error  = 1'b0;
        end
        repeat ($urandom_range(0, 3)) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        logic [3:0] l39[$];
        logic [3:0] l10[$];
        logic [3:0] q[$];
        l39 = '{4'd3, 4'd6, 4'd4, 4'd7, 4'd8, 4'd9, 4'd3, 4'd6, 4'd5, 4'd8, 4'd4, 4'd6, 4'd3, 4'd4};
        bus.in_valid  = 1'b0;
        bus.in_digit  = '0;
        bus.in_last   = 1'b0;
        bus.dp_done   = 1'b0;
        bus.dp_result = '0;
        bus.dp_error  = 1'b0;
        model_clear();

        repeat (3) @(negedge clk);
        expect_eq("reset_outs",
                  {bus.in_ready, bus.dp_start, bus.dp_valid, bus.dp_digit,
                   busy, error, lines_out, sum_out}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_line(l39, 1'b1, RES_W'(986), 1'b0, 1'b1, -1);
        expect_eq("req39_sum", sum_out, 986);
        run_line(l39, 1'b1, RES_W'(999), 1'b0, 1'b1, -1);
        expect_eq("req40_sum", sum_out, 1985);

        do_clr();
        for (int i = 0; i < 10; i++) l10.push_back(l39[i]);
        run_line(l10, 1'b1, RES_W'(98), 1'b0, 1'b1, -1);
        expect_eq("req41_sum", sum_out, 98);

        do_clr();
        run_line(l39, 1'b1, RES_W'(4000), 1'b0, 1'b1, -1);
        run_line(l39, 1'b1, RES_W'(100), 1'b0, 1'b1, -1);
        expect_eq("req43_sum", sum_out, 4);
        expect_eq("req43_err", error, 1);

        do_clr();
        run_line(l39, 1'b1, RES_W'(0), 1'b0, 1'b0, -1);

        do_clr();
        run_line(l39, 1'b1, RES_W'(986), 1'b0, 1'b1, -1);
        run_line(l39, 1'b1, RES_W'(5), 1'b0, 1'b1, 6);
        run_line(l39, 1'b1, RES_W'(777), 1'b0, 1'b1, -1);
        expect_eq("req44_sum", sum_out, 777);

        do_clr();
        run_line(l39, 1'b0, RES_W'(12), 1'b0, 1'b1, -1);

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 9) == 0) do_clr();
            random_line();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
